// File: rtl/infix_to_postfix.sv
// Shunting-yard infix-to-postfix converter feeding a postfix evaluator.
// Operators wait on an internal stack; emission is paced by DN_BUSY and a one-cycle holdoff.
module infix_to_postfix #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TOKEN_DAT,
  input  logic       TOKEN_IS_NUM,
  input  logic       TOKEN_STB,
  input  logic       END_STB,
  output logic       BUSY,
  input  logic       DN_BUSY,
  output logic [7:0] SIGN_OUT,
  output logic       SIGN_STB,
  output logic [7:0] NUMBER_OUT,
  output logic       NUMBER_STB,
  output logic       ERROR
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SpW  = $clog2(DEPTH + 1);
  localparam logic [SpW-1:0] SpFull = SpW'(DEPTH);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StEmitNum  = 3'd1;
  localparam logic [2:0] StPopPrec  = 3'd2;
  localparam logic [2:0] StPushOp   = 3'd3;
  localparam logic [2:0] StPopParen = 3'd4;
  localparam logic [2:0] StFlush    = 3'd5;
  localparam logic [2:0] StTerm     = 3'd6;
  localparam logic [2:0] StErr      = 3'd7;

  localparam logic [7:0] ChLParen = 8'h28;
  localparam logic [7:0] ChRParen = 8'h29;
  localparam logic [7:0] ChMul    = 8'h2A;
  localparam logic [7:0] ChAdd    = 8'h2B;
  localparam logic [7:0] ChSub    = 8'h2D;
  localparam logic [7:0] ChDiv    = 8'h2F;

  logic [2:0]     state_q, state_d;
  logic [7:0]     tok_q;
  logic [SpW-1:0] sp_q;
  logic [SpW-1:0] top_sp;
  logic [7:0]     stack_q [DEPTH];
  logic [7:0]     top;
  logic           push, pop, clear, load;
  logic           slot;
  logic           sign_stb, num_stb;
  logic [7:0]     sign_val, num_val;
  logic           stb_q, busy_q, error_q;
  logic [7:0]     sign_q, num_q;

  function automatic logic [1:0] prec(input logic [7:0] c);
    if (c == ChMul || c == ChDiv) return 2'd2;
    if (c == ChAdd || c == ChSub) return 2'd1;
    return 2'd0;
  endfunction

  assign top_sp = sp_q - 1'b1;
  assign top    = (sp_q != '0) ? stack_q[top_sp[IdxW-1:0]] : 8'h00;
  // No strobe two cycles in a row, so the evaluator can register its own busy.
  assign slot   = !DN_BUSY && !stb_q;

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    sign_stb = 1'b0;
    num_stb  = 1'b0;
    sign_val = top;
    num_val  = tok_q;
    unique case (state_q)
      StIdle: begin
        if (END_STB) begin
          state_d = StFlush;
        end else if (TOKEN_STB) begin
          load = 1'b1;
          if (TOKEN_IS_NUM) state_d = StEmitNum;
          else if (TOKEN_DAT == ChAdd || TOKEN_DAT == ChSub ||
                   TOKEN_DAT == ChMul || TOKEN_DAT == ChDiv) state_d = StPopPrec;
          else if (TOKEN_DAT == ChLParen) state_d = StPushOp;
          else if (TOKEN_DAT == ChRParen) state_d = StPopParen;
          else state_d = StErr;
        end
      end
      StEmitNum: begin
        if (slot) begin
          num_stb = 1'b1;
          state_d = StIdle;
        end
      end
      StPopPrec: begin
        if (sp_q != '0 && top != ChLParen && prec(top) >= prec(tok_q)) begin
          if (slot) begin
            sign_stb = 1'b1;
            pop      = 1'b1;
          end
        end else begin
          state_d = StPushOp;
        end
      end
      StPushOp: begin
        if (sp_q == SpFull) begin
          state_d = StErr;
        end else begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      StPopParen: begin
        if (sp_q == '0) begin
          state_d = StErr;
        end else if (top == ChLParen) begin
          pop     = 1'b1;
          state_d = StIdle;
        end else if (slot) begin
          sign_stb = 1'b1;
          pop      = 1'b1;
        end
      end
      StFlush: begin
        if (sp_q == '0) begin
          state_d = StTerm;
        end else if (top == ChLParen) begin
          state_d = StErr;
        end else if (slot) begin
          sign_stb = 1'b1;
          pop      = 1'b1;
        end
      end
      StTerm: begin
        sign_val = 8'h00;
        num_val  = 8'h00;
        if (slot) begin
          sign_stb = 1'b1;
          num_stb  = 1'b1;
          clear    = 1'b1;
          state_d  = StIdle;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      tok_q   <= 8'h00;
      sp_q    <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      sign_q  <= 8'h00;
      num_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      if (load) tok_q <= TOKEN_DAT;
      if (clear) sp_q <= '0;
      else if (push) sp_q <= sp_q + 1'b1;
      else if (pop) sp_q <= sp_q - 1'b1;
      stb_q   <= sign_stb | num_stb;
      busy_q  <= (state_d != StIdle);
      error_q <= error_q | (state_d == StErr);
      if (sign_stb) sign_q <= sign_val;
      if (num_stb) num_q <= num_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) stack_q[sp_q[IdxW-1:0]] <= tok_q;
  end

  assign BUSY       = busy_q;
  assign ERROR      = error_q;
  assign SIGN_STB   = sign_stb;
  assign NUMBER_STB = num_stb;
  assign SIGN_OUT   = sign_stb ? sign_val : sign_q;
  assign NUMBER_OUT = num_stb ? num_val : num_q;

endmodule

// File: tb/tb_infix_to_postfix.sv
// Directed bench for infix_to_postfix: records every strobe and compares against
// hand-derived postfix sequences, plus error, stall and reset scenarios.
module tb_infix_to_postfix;

  localparam logic [7:0] LP = 8'h28;
  localparam logic [7:0] RP = 8'h29;
  localparam logic [7:0] MU = 8'h2A;
  localparam logic [7:0] PL = 8'h2B;
  localparam logic [7:0] MI = 8'h2D;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] TOKEN_DAT;
  logic       TOKEN_IS_NUM, TOKEN_STB, END_STB, DN_BUSY;
  logic       BUSY, SIGN_STB, NUMBER_STB, ERROR;
  logic [7:0] SIGN_OUT, NUMBER_OUT;

  int n_tests = 0;
  int n_fail  = 0;
  int gap_viol = 0;
  int busy_viol = 0;
  logic prev_stb = 1'b0;
  // Entries are {kind, value}: kind 1 number, 2 sign, 3 terminator.
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  always #5 CLK = ~CLK;

  infix_to_postfix #(.DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .TOKEN_DAT(TOKEN_DAT), .TOKEN_IS_NUM(TOKEN_IS_NUM),
    .TOKEN_STB(TOKEN_STB), .END_STB(END_STB), .BUSY(BUSY), .DN_BUSY(DN_BUSY),
    .SIGN_OUT(SIGN_OUT), .SIGN_STB(SIGN_STB), .NUMBER_OUT(NUMBER_OUT),
    .NUMBER_STB(NUMBER_STB), .ERROR(ERROR)
  );

  always @(negedge CLK) begin
    #2;
    if (!RST) begin
      prev_stb = 1'b0;
    end else begin
      if (SIGN_STB || NUMBER_STB) begin
        if (prev_stb) gap_viol++;
        if (DN_BUSY) busy_viol++;
        if (SIGN_STB && NUMBER_STB) got_q.push_back({2'd3, SIGN_OUT | NUMBER_OUT});
        else if (SIGN_STB) got_q.push_back({2'd2, SIGN_OUT});
        else got_q.push_back({2'd1, NUMBER_OUT});
      end
      prev_stb = SIGN_STB || NUMBER_STB;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic en(input logic [7:0] v); exp_q.push_back({2'd1, v}); endtask
  task automatic es(input logic [7:0] v); exp_q.push_back({2'd2, v}); endtask
  task automatic et(); exp_q.push_back(10'h300); endtask

  task automatic check_seq(input string tag);
    check($sformatf("%s.count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? got_q[i] : 10'h000, exp_q[i]);
    check($sformatf("%s.gap", tag), gap_viol, 0);
    check($sformatf("%s.dn_busy", tag), busy_viol, 0);
    got_q.delete();
    exp_q.delete();
    gap_viol = 0;
    busy_viol = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && BUSY; n++) @(negedge CLK);
    check("idle_wait", BUSY, 0);
  endtask

  task automatic send_tok(input logic [7:0] d, input logic num);
    wait_idle();
    @(negedge CLK);
    TOKEN_DAT = d; TOKEN_IS_NUM = num; TOKEN_STB = 1'b1;
    @(negedge CLK);
    TOKEN_STB = 1'b0;
  endtask

  task automatic send_end();
    wait_idle();
    @(negedge CLK);
    END_STB = 1'b1;
    @(negedge CLK);
    END_STB = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b0;
    #2;
    check("rst.error", ERROR, 0);
    check("rst.busy", BUSY, 0);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic wait_count(input int n);
    for (int k = 0; k < 200 && got_q.size() < n; k++) @(negedge CLK);
  endtask

  task automatic case1_tokens();
    send_tok(8'd3, 1'b1);
    send_tok(PL, 1'b0);
    send_tok(8'd4, 1'b1);
    send_tok(MU, 1'b0);
    send_tok(8'd2, 1'b1);
    send_end();
  endtask

  initial begin
    RST = 1'b0; TOKEN_DAT = 8'h00; TOKEN_IS_NUM = 1'b0; TOKEN_STB = 1'b0;
    END_STB = 1'b0; DN_BUSY = 1'b0;
    #3;
    check("reset.busy", BUSY, 0);
    check("reset.error", ERROR, 0);
    check("reset.sign_stb", SIGN_STB, 0);
    check("reset.number_stb", NUMBER_STB, 0);
    check("reset.sign_out", SIGN_OUT, 0);
    check("reset.number_out", NUMBER_OUT, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // 3 + 4 * 2, with number latency and an ignored token while busy
    send_tok(8'd3, 1'b1);
    #2;
    check("lat.number_stb", NUMBER_STB, 1);
    check("lat.number_out", NUMBER_OUT, 8'd3);
    @(negedge CLK); #2;
    check("lat.busy_low", BUSY, 0);
    check("lat.hold", NUMBER_OUT, 8'd3);
    send_tok(PL, 1'b0);
    send_tok(8'd4, 1'b1);
    send_tok(MU, 1'b0);
    send_tok(8'd2, 1'b1);
    send_end();
    TOKEN_DAT = 8'd9; TOKEN_IS_NUM = 1'b1; TOKEN_STB = 1'b1;
    @(negedge CLK);
    TOKEN_STB = 1'b0;
    wait_idle();
    en(8'd3); en(8'd4); en(8'd2); es(MU); es(PL); et();
    check_seq("c1");

    // ( 1 + 2 ) * 3
    send_tok(LP, 1'b0);
    send_tok(8'd1, 1'b1);
    send_tok(PL, 1'b0);
    send_tok(8'd2, 1'b1);
    send_tok(RP, 1'b0);
    send_tok(MU, 1'b0);
    send_tok(8'd3, 1'b1);
    send_end();
    wait_idle();
    en(8'd1); en(8'd2); es(PL); en(8'd3); es(MU); et();
    check_seq("c2");

    // 8 - 3 - 2, left associativity
    send_tok(8'd8, 1'b1);
    send_tok(MI, 1'b0);
    send_tok(8'd3, 1'b1);
    send_tok(MI, 1'b0);
    send_tok(8'd2, 1'b1);
    send_end();
    wait_idle();
    en(8'd8); en(8'd3); es(MI); en(8'd2); es(MI); et();
    check_seq("c3");

    // stack overflow at depth 4
    for (int i = 0; i < 5; i++) send_tok(LP, 1'b0);
    repeat (5) @(negedge CLK);
    check("ovf.error", ERROR, 1);
    check("ovf.busy", BUSY, 1);
    END_STB = 1'b1;
    @(negedge CLK);
    END_STB = 1'b0;
    repeat (8) @(negedge CLK);
    check("ovf.busy_held", BUSY, 1);
    check_seq("ovf");
    pulse_reset();

    // empty expression: immediate terminator, also shows the stack was cleared
    send_end();
    wait_idle();
    check("empty.error", ERROR, 0);
    et();
    check_seq("empty");

    // ')' first
    send_tok(RP, 1'b0);
    repeat (5) @(negedge CLK);
    check("rp.error", ERROR, 1);
    check_seq("rp");
    pulse_reset();

    // ( 5 END: unmatched paren at flush
    send_tok(LP, 1'b0);
    send_tok(8'd5, 1'b1);
    send_end();
    repeat (10) @(negedge CLK);
    check("unm.error", ERROR, 1);
    check("unm.busy", BUSY, 1);
    en(8'd5);
    check_seq("unm");
    pulse_reset();

    // downstream stall mid-flush
    case1_tokens();
    wait_count(4);
    check("stall.reach", got_q.size(), 4);
    DN_BUSY = 1'b1;
    repeat (10) @(negedge CLK);
    check("stall.held", got_q.size(), 4);
    DN_BUSY = 1'b0;
    wait_idle();
    en(8'd3); en(8'd4); en(8'd2); es(MU); es(PL); et();
    check_seq("stall");

    // reset mid-flush: pending '+' and terminator are dropped
    case1_tokens();
    wait_count(4);
    RST = 1'b0;
    #2;
    check("mid.busy", BUSY, 0);
    check("mid.sign_out", SIGN_OUT, 0);
    check("mid.number_out", NUMBER_OUT, 0);
    check("mid.strobes", {SIGN_STB, NUMBER_STB}, 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (8) @(negedge CLK);
    check("mid.busy_after", BUSY, 0);
    en(8'd3); en(8'd4); en(8'd2); es(MU);
    check_seq("mid");
    send_end();
    wait_idle();
    et();
    check_seq("mid.empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/infix_to_postfix.md
# infix_to_postfix

Shunting-yard converter directly upstream of the postfix evaluator. Accepts an infix expression one 8-bit token per strobe, reorders it with an internal operator stack, and emits postfix tokens on the evaluator's sign/number strobe interface. Emission is paced by the evaluator's BUSY. The expression is closed with the evaluator's end-of-expression marker: SIGN_STB and NUMBER_STB asserted together.

## Interface
- DEPTH, 16: operator stack entries (ASCII operators and '('); minimum 2.
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset; asynchronous, active-low.
- TOKEN_DAT  input  8  token: number value if TOKEN_IS_NUM, else ASCII '+', '-', '*', '/', '(' or ')'.
- TOKEN_IS_NUM  input  1  qualifies TOKEN_DAT as a number.
- TOKEN_STB  input  1  single-cycle token pulse; accepted only when BUSY=0.
- END_STB  input  1  single-cycle end-of-expression pulse; accepted only when BUSY=0; TOKEN_STB ignored in the same cycle.
- BUSY  output  1  registered; 1 while a token or end is being processed, or ERROR is set.
- DN_BUSY  input  1  evaluator BUSY; 1 blocks emission.
- SIGN_OUT  output  8  operator to evaluator.
- SIGN_STB  output  1  single-cycle operator strobe.
- NUMBER_OUT  output  8  number to evaluator.
- NUMBER_STB  output  1  single-cycle number strobe.
- ERROR  output  1  sticky syntax/overflow flag; cleared only by reset.

## Operation
- Precedence: '*', '/' = 2; '+', '-' = 1; '(' = 0. All operators are left-associative.
- States: IDLE, EMIT_NUM, POP_PREC, PUSH_OP, POP_PAREN, FLUSH, TERM, ERR.
- IDLE, token or end accepted: BUSY goes 1 on the next cycle.
  - Number → EMIT_NUM.
  - Operator → POP_PREC.
  - '(' → PUSH_OP.
  - ')' → POP_PAREN.
  - END_STB → FLUSH.
  - Any other ASCII → ERR.
- EMIT_NUM: emit NUMBER_OUT = token, then go to IDLE.
- POP_PREC: while top-of-stack is not '(' and its precedence ≥ the incoming precedence, pop it and emit it on SIGN_OUT, one per emit slot. Then go to PUSH_OP.
- PUSH_OP: push the token. If the stack is full → ERR. Otherwise → IDLE.
- POP_PAREN: pop and emit until '(' is on top. Discard the '(' (no emission), then go to IDLE. Stack empty before '(' is found → ERR.
- FLUSH: pop and emit every operator. A '(' found in the stack → ERR. Stack empty → TERM.
- TERM: in one emit slot, assert SIGN_STB and NUMBER_STB together with SIGN_OUT = 0 and NUMBER_OUT = 0. Stack is cleared, BUSY drops, state returns to IDLE.
- ERR: no further emission. BUSY = 1 and ERROR = 1 until reset.
- Emit slot: a cycle in which DN_BUSY = 0 and no strobe was driven in the previous cycle. This guarantees at least one idle cycle between strobes, so the evaluator can register its own busy.
- Stack: synchronous push/pop; one operation per cycle. Pop and emit of the same entry occur in the same cycle.

## Timing
- Reset (RST = 0, asynchronous): BUSY = 0, ERROR = 0, SIGN_STB = 0, NUMBER_STB = 0, SIGN_OUT = 0, NUMBER_OUT = 0, stack empty, state IDLE.
  - Reset mid-operation discards the stack and all pending output.
  - No strobe is issued in the cycle after release.
- Number latency: accepted at edge t → NUMBER_STB high in cycle t+1 if DN_BUSY = 0. BUSY is 0 in cycle t+2.
- Operator with no pops: BUSY high for 2 cycles (POP_PREC, PUSH_OP).
- Each pop emission costs at least 2 cycles (strobe cycle plus holdoff cycle). DN_BUSY = 1 extends this without limit.
- Strobes are exactly one cycle long. SIGN_OUT and NUMBER_OUT are valid only while their strobe is high and hold their last value otherwise.
- TOKEN_STB or END_STB while BUSY = 1: ignored, no state change.
- END_STB on an empty expression: TERM is emitted immediately, with no error.

## Test plan
- Tokens 3, '+', 4, '*', 2, END with DN_BUSY = 0 → strobes in order: N3, N4, N2, S'*', S'+', then dual strobe. Each strobe is separated by at least one idle cycle.
- '(', 1, '+', 2, ')', '*', 3, END → N1, N2, S'+', N3, S'*', terminator. No '(' or ')' is ever emitted.
- 8, '-', 3, '-', 2, END → N8, N3, S'-', N2, S'-' (left associativity), terminator.
- DEPTH = 4; five '(' tokens → ERROR = 1 after the fifth. BUSY stays 1 and no strobes follow. RST = 0 clears both.
- ')' as first token → ERROR = 1, no strobe. Separately: '(', 5, END → N5, then ERROR = 1 with no terminator.
- Case 1 with DN_BUSY held 1 for 10 cycles during the flush → emission stalls with no strobe and no lost token, then resumes in order. Asserting RST mid-flush → all outputs 0 and no terminator.
